// File: rtl/seg7_scan_multi_if.sv
// Bundle between the value-producing logic and the 7-segment scanner.
// There is no valid/ready pair on this bus: the producer holds data_in,
// dp_in, blank_in and lz_en steady-state, and the scanner samples them
// only on the edge where sel wraps from the last digit back to digit 0.
// Any value present on that edge is accepted. Changes in between are
// ignored until the next wrap. sel/seg/frame_start flow back to the board.
interface seg7_scan_multi_if #(
  parameter int DIGITS = 6
);
  localparam int SELW = (DIGITS > 2) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] data_in;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   blank_in;
  logic                lz_en;
  logic [SELW-1:0]     sel;
  logic [7:0]          seg;
  logic                frame_start;

  // Producer side: drives the display contents, observes the scan
  modport master (
    output data_in, dp_in, blank_in, lz_en,
    input  sel, seg, frame_start
  );

  // Scanner side
  modport slave (
    input  data_in, dp_in, blank_in, lz_en,
    output sel, seg, frame_start
  );
endinterface

// File: rtl/seg7_scan_multi.sv
// Parametrised time-multiplexed 7-segment scanner. Inputs are captured
// once per frame (on the sel wrap), so a frame never mixes old and new
// data. sel and seg are registered together: seg always encodes the
// digit that sel currently selects.
module seg7_scan_multi #(
  parameter int DIGITS         = 6,
  parameter int SCAN_DIV       = 1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input logic              clk_1k,
  input logic              rst_n,
  seg7_scan_multi_if.slave bus
);
  localparam int SELW = (DIGITS > 2) ? $clog2(DIGITS) : 1;
  localparam int DIVW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SELW-1:0] LAST_SEL = SELW'(DIGITS - 1);
  localparam logic [DIVW-1:0] LAST_DIV = DIVW'(SCAN_DIV - 1);
  localparam logic [7:0]      SEG_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  // Active-low hex codes with the decimal point off (bit7 = 1)
  function automatic logic [7:0] hex8(input logic [3:0] n);
    logic [7:0] c;
    case (n)
      4'h0: c = 8'hC0;
      4'h1: c = 8'hF9;
      4'h2: c = 8'hA4;
      4'h3: c = 8'hB0;
      4'h4: c = 8'h99;
      4'h5: c = 8'h92;
      4'h6: c = 8'h82;
      4'h7: c = 8'hF8;
      4'h8: c = 8'h80;
      4'h9: c = 8'h90;
      4'hA: c = 8'h88;
      4'hB: c = 8'h83;
      4'hC: c = 8'hC6;
      4'hD: c = 8'hA1;
      4'hE: c = 8'h86;
      default: c = 8'h8E;
    endcase
    return c;
  endfunction

  logic [DIVW-1:0]     div_cnt;
  logic [SELW-1:0]     sel_q;
  logic [7:0]          seg_q;
  logic                frame_start_q;

  logic [4*DIGITS-1:0] sh_data;
  logic [DIGITS-1:0]   sh_dp;
  logic [DIGITS-1:0]   sh_blank;
  logic                sh_lz;

  logic                tick;
  logic                wrap;
  logic [SELW-1:0]     next_sel;

  logic [4*DIGITS-1:0] src_data;
  logic [DIGITS-1:0]   src_dp;
  logic [DIGITS-1:0]   src_blank;
  logic                src_lz;
  logic [3:0]          nib_i;
  logic                zero_run;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;
  logic                cur_sup;
  logic [7:0]          seg_code;
  logic [7:0]          seg_next;

  assign tick     = (div_cnt == LAST_DIV);
  assign wrap     = tick && (sel_q == LAST_SEL);
  assign next_sel = (sel_q == LAST_SEL) ? '0 : sel_q + 1'b1;

  // On the wrap edge the live inputs are what the shadow is about to hold,
  // so decoding from them keeps digit 0 consistent with the rest of the frame
  always_comb begin
    src_data  = wrap ? bus.data_in  : sh_data;
    src_dp    = wrap ? bus.dp_in    : sh_dp;
    src_blank = wrap ? bus.blank_in : sh_blank;
    src_lz    = wrap ? bus.lz_en    : sh_lz;
    nib_i     = '0;
    zero_run  = 1'b1;
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_sup   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      nib_i    = src_data[4*(DIGITS-1-i) +: 4];
      zero_run = zero_run && (nib_i == 4'h0);
      if (next_sel == SELW'(i)) begin
        cur_nib   = nib_i;
        cur_dp    = src_dp[i];
        cur_blank = src_blank[i];
        // The last digit is never suppressed so zero still shows "0"
        cur_sup   = src_lz && zero_run && (i != DIGITS - 1);
      end
    end
  end

  // Build the segment code: hex, then suppression, dp, blanking, polarity
  always_comb begin
    seg_code = hex8(cur_nib);
    if (cur_sup)   seg_code[6:0] = 7'h7F;
    if (cur_dp)    seg_code[7]   = 1'b0;
    if (cur_blank) seg_code      = 8'hFF;
    seg_next = SEG_ACTIVE_LOW ? seg_code : ~seg_code;
  end

  // Scan-rate prescaler; with SCAN_DIV=1 it sits at 0 and tick stays high
  always_ff @(posedge clk_1k or negedge rst_n) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // Digit select and its segment code advance together on each tick
  always_ff @(posedge clk_1k or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= LAST_SEL;
      seg_q <= SEG_OFF;
    end else if (tick) begin
      sel_q <= next_sel;
      seg_q <= seg_next;
    end
  end

  // One-cycle marker for the first slot of each frame
  always_ff @(posedge clk_1k or negedge rst_n) begin
    if (!rst_n) frame_start_q <= 1'b0;
    else        frame_start_q <= wrap;
  end

  // Frame snapshot of the display inputs
  always_ff @(posedge clk_1k or negedge rst_n) begin
    if (!rst_n) begin
      sh_data  <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
      sh_lz    <= 1'b0;
    end else if (wrap) begin
      sh_data  <= bus.data_in;
      sh_dp    <= bus.dp_in;
      sh_blank <= bus.blank_in;
      sh_lz    <= bus.lz_en;
    end
  end

  assign bus.sel         = sel_q;
  assign bus.seg         = seg_q;
  assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_seg7_scan_multi.sv
// Directed bench for seg7_scan_multi: a default instance (6 digits,
// SCAN_DIV=1, active-low) and a slow inverted-polarity instance
// (SCAN_DIV=4, SEG_ACTIVE_LOW=0) sharing one clock.
module tb_seg7_scan_multi;
  logic clk_1k;
  logic rst_n;
  logic rst_b_n;

  int total;
  int bad;
  int fs_pulses;

  seg7_scan_multi_if #(.DIGITS(6)) bus_a ();
  seg7_scan_multi_if #(.DIGITS(6)) bus_b ();

  seg7_scan_multi #(.DIGITS(6), .SCAN_DIV(1), .SEG_ACTIVE_LOW(1'b1)) dut_a (
    .clk_1k (clk_1k),
    .rst_n  (rst_n),
    .bus    (bus_a.slave)
  );

  seg7_scan_multi #(.DIGITS(6), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0)) dut_b (
    .clk_1k (clk_1k),
    .rst_n  (rst_b_n),
    .bus    (bus_b.slave)
  );

  // Clock
  initial clk_1k = 1'b0;
  always #5 clk_1k = ~clk_1k;

  // Advance one clock and sample just after the edge
  task automatic step();
    @(posedge clk_1k);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int s, input logic [7:0] sg, input logic fs);
    chk8({tag, ".sel"}, 8'(bus_a.sel), 8'(s));
    chk8({tag, ".seg"}, bus_a.seg, sg);
    chk8({tag, ".fs"},  8'(bus_a.frame_start), 8'(fs));
  endtask

  // Run one full frame on instance A starting from the wrap edge
  task automatic frame_a(input string tag, input logic [7:0] exp[6]);
    for (int i = 0; i < 6; i++) begin
      step();
      chk_a($sformatf("%s.slot%0d", tag, i), i, exp[i], (i == 0));
    end
  endtask

  initial begin
    logic [7:0] e[6];
    int k;
    total     = 0;
    bad       = 0;
    fs_pulses = 0;
    rst_n     = 1'b0;
    rst_b_n   = 1'b0;
    bus_a.data_in  = 24'h012345;
    bus_a.dp_in    = '0;
    bus_a.blank_in = '0;
    bus_a.lz_en    = 1'b0;
    bus_b.data_in  = 24'h888888;
    bus_b.dp_in    = '0;
    bus_b.blank_in = '0;
    bus_b.lz_en    = 1'b0;

    // Reset state
    repeat (3) step();
    chk_a("rst_a", 5, 8'hFF, 1'b0);
    chk8("rst_b.seg", bus_b.seg, 8'h00);
    chk8("rst_b.sel", 8'(bus_b.sel), 8'd5);
    chk8("rst_b.fs",  8'(bus_b.frame_start), 8'd0);

    // First frame after release, with a mid-frame input change
    rst_n = 1'b1;
    step(); chk_a("f0.slot0", 0, 8'hC0, 1'b1);
    step(); chk_a("f0.slot1", 1, 8'hF9, 1'b0);
    step(); chk_a("f0.slot2", 2, 8'hA4, 1'b0);
    bus_a.data_in = 24'hFFFFFF;
    step(); chk_a("snap.slot3", 3, 8'hB0, 1'b0);
    step(); chk_a("snap.slot4", 4, 8'h99, 1'b0);
    step(); chk_a("snap.slot5", 5, 8'h92, 1'b0);
    e = '{8'h8E, 8'h8E, 8'h8E, 8'h8E, 8'h8E, 8'h8E};
    frame_a("allF", e);

    // Leading-zero suppression
    bus_a.lz_en   = 1'b1;
    bus_a.data_in = 24'h000705;
    e = '{8'hFF, 8'hFF, 8'hFF, 8'hF8, 8'hC0, 8'h92};
    frame_a("lz705", e);
    bus_a.data_in = 24'h000000;
    e = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0};
    frame_a("lz0", e);
    bus_a.dp_in = 6'b000010;
    e = '{8'hFF, 8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hC0};
    frame_a("lz0dp1", e);

    // Decimal point and blanking
    bus_a.lz_en   = 1'b0;
    bus_a.data_in = 24'h012345;
    bus_a.dp_in   = 6'b000100;
    e = '{8'hC0, 8'hF9, 8'h24, 8'hB0, 8'h99, 8'h92};
    frame_a("dp2", e);
    bus_a.dp_in    = 6'b000001;
    bus_a.blank_in = 6'b000001;
    e = '{8'hFF, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92};
    frame_a("blank0", e);

    // Asynchronous reset in the middle of a frame, while frame_start is high
    bus_a.dp_in    = '0;
    bus_a.blank_in = '0;
    step(); chk_a("pre_arst", 0, 8'hC0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_a("arst", 5, 8'hFF, 1'b0);
    step(); chk_a("arst_hold", 5, 8'hFF, 1'b0);
    rst_n = 1'b1;
    e = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92};
    frame_a("post_arst", e);

    // Slow, inverted instance: sel moves on every 4th edge
    rst_b_n = 1'b1;
    for (int n = 1; n <= 48; n++) begin
      step();
      k = n / 4;
      if (bus_b.frame_start === 1'b1) fs_pulses++;
      chk8($sformatf("b.c%0d.sel", n), 8'(bus_b.sel), (n < 4) ? 8'd5 : 8'((k - 1) % 6));
      chk8($sformatf("b.c%0d.seg", n), bus_b.seg, (n < 4) ? 8'h00 : 8'h7F);
      chk8($sformatf("b.c%0d.fs", n), 8'(bus_b.frame_start), (n % 24 == 4) ? 8'd1 : 8'd0);
    end
    chk8("b.fs_pulses", 8'(fs_pulses), 8'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
